// File: rtl/spi_pkg.sv
// Shared types and constants for the sequenced SPI master.
// Frames are a 2-bit command code followed by 8 payload bits.
package spi_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        SHIFT,
        TURN,
        RECV,
        GAP,
        DONE
    } state_t;

    typedef logic [FRAME_W-1:0] frame_t;

    function automatic frame_t make_frame(
        input logic [1:0]        cmd,
        input logic [DATA_W-1:0] data
    );
        return {cmd, data};
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// 4-bit loadable down-counter that saturates at zero.
// Timed FSM states reload it on entry and leave when it reads zero.
module spi_bit_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/spi_master_seq.sv
// Two-frame SPI master sequencing register writes and reads.
// State and all outputs are registered from the next-state decode.
module spi_master_seq
    import spi_pkg::*;
#(
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned TURN_CYC = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [3:0] SHIFT_LD = 4'(FRAME_W - 1);
    localparam logic [3:0] RECV_LD  = 4'(DATA_W - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_CYC - 1);
    localparam logic [3:0] TURN_LD  =
        (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        cnt_load;
    logic [3:0]  cnt_val;
    logic        cnt_zero;
    logic        second;
    logic        op_q;
    logic [7:0]  wdata_q;
    frame_t      sh;
    logic [7:0]  rx;

    assign accept = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = SETUP;
            SETUP: state_nxt = CMD;
            CMD:   state_nxt = SHIFT;
            SHIFT: begin
                if (cnt_zero) begin
                    if (second && op_q)
                        state_nxt = (TURN_CYC == 0) ? RECV : TURN;
                    else
                        state_nxt = GAP;
                end
            end
            TURN:  if (cnt_zero) state_nxt = RECV;
            RECV:  if (cnt_zero) state_nxt = GAP;
            GAP:   if (cnt_zero) state_nxt = second ? DONE : SETUP;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every state change reloads the counter for the state being entered.
    always_comb begin
        cnt_load = (state_nxt != state);
        cnt_val  = 4'd0;
        unique case (state_nxt)
            SHIFT:   cnt_val = SHIFT_LD;
            TURN:    cnt_val = TURN_LD;
            RECV:    cnt_val = RECV_LD;
            GAP:     cnt_val = GAP_LD;
            default: cnt_val = 4'd0;
        endcase
    end

    spi_bit_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (!cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            second    <= 1'b0;
            op_q      <= 1'b0;
            wdata_q   <= 8'h00;
            sh        <= '0;
            rx        <= 8'h00;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == DONE);

            if (accept) begin
                op_q    <= req_op;
                wdata_q <= req_wdata;
                second  <= 1'b0;
                sh      <= make_frame(
                    req_op ? CMD_RD_ADDR : CMD_WR_ADDR, req_addr);
            end

            if (state == GAP && state_nxt == SETUP) begin
                second <= 1'b1;
                sh     <= op_q ? make_frame(CMD_RD_DATA, 8'h00)
                               : make_frame(CMD_WR_DATA, wdata_q);
            end

            // LSB arrives first, so after eight shifts it sits in bit 0.
            if (state == RECV)
                rx <= {MISO, rx[7:1]};

            unique case (state_nxt)
                SETUP: begin
                    SS_n <= 1'b0;
                    MOSI <= 1'b0;
                end
                CMD: begin
                    SS_n <= 1'b0;
                    MOSI <= sh[FRAME_W-1];
                end
                SHIFT: begin
                    SS_n <= 1'b0;
                    MOSI <= sh[0];
                    sh   <= sh >> 1;
                end
                TURN, RECV: begin
                    SS_n <= 1'b0;
                    MOSI <= 1'b0;
                end
                default: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                end
            endcase

            if (state_nxt == DONE && op_q)
                rsp_rdata <= rx;
        end
    end

endmodule
